output_argmax: RTL
==================

# output_argmax

Downstream classification stage for the neural accelerator. It consumes the stream of 8-bit neuron results that the MAC core produces for the final layer and tracks the running signed maximum and its index. When the layer's last value arrives it presents a registered winning class, score and beat count on a valid/ready output port. It holds that result until the consumer accepts it, and back-pressures the input while it waits.

## Interface
Parameters:
- DATA_W, 8, width of one neuron value (two's complement)
- IDX_W, 8, width of class index and beat counter; one layer holds at most 2^IDX_W values

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_data  input  DATA_W  neuron value, signed
- in_valid  input  1  in_data is valid this cycle
- in_last  input  1  marks the final value of the layer; meaningful only when in_valid=1
- in_ready  output  1  stage accepts a beat this cycle
- out_valid  output  1  result registers hold a complete layer result
- out_ready  input  1  consumer takes the result this cycle
- class_idx  output  IDX_W  index (0-based) of the maximum value
- class_score  output  DATA_W  the maximum value, signed
- beat_count  output  IDX_W+1  number of values in the layer
- overflow  output  1  the layer exceeded 2^IDX_W values; valid together with out_valid

## Operation
- Beat accepted: in_valid & in_ready.
- Two states:
  - SCAN: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- SCAN, on each accepted beat (cnt = values accepted so far this layer):
  - If cnt==0, or $signed(in_data) > $signed(max_r): max_r <= in_data, idx_r <= cnt[IDX_W-1:0].
  - Ties keep the earlier index, because the comparison is strictly greater.
  - cnt <= cnt+1, saturating at 2^IDX_W.
  - If cnt==2^IDX_W on entry (the beat would be value number 2^IDX_W+1): ovf_r <= 1, max_r/idx_r are not updated, cnt stays saturated.
  - If in_last=1: go to HOLD. class_idx/class_score/beat_count/overflow are then driven from idx_r/max_r/cnt/ovf_r with the final beat included.
- HOLD:
  - While out_ready=0, outputs are stable and no input beat is accepted.
  - When out_ready=1: go to SCAN, and clear cnt and ovf_r to 0. max_r and idx_r are left as they are; the cnt==0 rule overwrites them on the next layer.
- Single-beat layer (first beat has in_last=1): class_idx=0, class_score=in_data, beat_count=1.
- in_last is ignored when in_valid=0.
- Reset, from any state including mid-layer or during HOLD, applies immediately:
  - state=SCAN, cnt=0, max_r=0, idx_r=0, ovf_r=0.
  - Outputs: out_valid=0, in_ready=1, class_idx=0, class_score=0, beat_count=0, overflow=0.
  - A partial layer is discarded.

## Timing
- All outputs are registered or decoded only from the state register. There is no combinational path from in_* or out_ready to any output.
- Latency: out_valid rises on the clock edge that accepts the in_last beat, and is visible in the following cycle.
- Throughput: one beat per cycle in SCAN.
- Turnaround after a handshake:
  - The result is accepted on edge N.
  - in_ready=1 in cycle N+1.
  - This gives at least one bubble cycle between layers.
- The minimum layer period is beats+1 cycles when out_ready is held high.
- Reset deasserting near a clock edge is the integrator's concern. The top already re-times reset on negedge, and the block itself adds no synchroniser.

## Structure
- Shared package nn_pkg:
  - localparam NN_DATA_W=8 and NN_IDX_W=8.
  - The state enum {ST_SCAN, ST_HOLD}, so the top and the bench use the same encodings.
- One natural sub-module, argmax_cmp: a combinational signed compare-and-select (inputs: candidate value and index, current max and index, first flag; outputs: next max and next index). It is reused unchanged if a multi-lane version is built later.
- Everything else lives in output_argmax: the FSM, the counter and the overflow logic. Target size is about 150-250 lines.

## Test plan
- Basic layer: stream 10,-3,42,7,42(last) with out_ready=1 -> class_idx=2, class_score=42, beat_count=5, overflow=0; out_valid high for exactly 1 cycle.
- All negative and single-beat:
  - Stream -128,-5,-9(last) -> class_idx=1, class_score=-5.
  - Then a single beat 0x80 with in_last -> class_idx=0, class_score=-128, beat_count=1.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after last -> outputs stable and in_ready=0 throughout, with in_valid driven high.
  - Assert out_ready -> in_ready=1 the next cycle, and the next layer's result is independent of the previous one.
- Input gaps: random in_valid gaps within a layer of 1,2,...,8(last) -> class_idx=7, class_score=8, beat_count=8; gaps do not change the result.
- Overflow: 257 beats with IDX_W=8, the max at index 255 (value 100) and beat 257 = 127 (last) -> overflow=1, class_idx=255, class_score=100, beat_count=256.
- Reset mid-operation:
  - Assert reset asynchronously (between edges) after 3 beats -> out_valid=0, in_ready=1 and all outputs 0 immediately.
  - A following layer 5,6(last) -> class_idx=1, beat_count=2.
  - Repeat with reset asserted during HOLD -> same recovery.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the neural accelerator output stages.
// Provides the default datapath widths and the argmax FSM state encoding,
// so the RTL and any bench agree on the numeric state values.
package nn_pkg;

    localparam int NN_DATA_W = 8;
    localparam int NN_IDX_W  = 8;

    // SCAN: collecting a layer.  HOLD: presenting a finished result.
    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Combinational signed compare-and-select for a running argmax.
// Ports:
//   cand_val / cand_idx : incoming value and its index
//   cur_max  / cur_idx  : running maximum and its index
//   first               : candidate is the first value of a layer; take it
//                         unconditionally
//   next_max / next_idx : updated maximum and index
// The comparison is strictly greater, so on a tie the earlier index stays.
module argmax_cmp #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 8
) (
    input  logic [DATA_W-1:0] cand_val,
    input  logic [IDX_W-1:0]  cand_idx,
    input  logic [DATA_W-1:0] cur_max,
    input  logic [IDX_W-1:0]  cur_idx,
    input  logic              first,
    output logic [DATA_W-1:0] next_max,
    output logic [IDX_W-1:0]  next_idx
);

    logic take;

    always_comb begin
        take = first || ($signed(cand_val) > $signed(cur_max));
        if (take) begin
            next_max = cand_val;
            next_idx = cand_idx;
        end else begin
            next_max = cur_max;
            next_idx = cur_idx;
        end
    end

endmodule

// File: rtl/output_argmax.sv
// Final-layer classification stage: tracks the running signed maximum of a
// stream of neuron values and its index, then presents the winning class,
// score, beat count and overflow flag until the consumer takes them.
//
// Ports:
//   clk, reset          : clock; asynchronous active-high reset
//   in_data/in_valid/in_last/in_ready : input neuron stream
//   out_valid/out_ready : result handshake
//   class_idx, class_score, beat_count, overflow : registered result
//   fsm_state           : current FSM state, for observation
//
// Handshake: both ports use valid/ready. A transfer happens on a rising
// edge where valid and ready are both high; the producer keeps valid and its
// data stable until that edge, and ready never depends combinationally on
// valid. Here in_ready and out_valid are pure decodes of the state register.
module output_argmax
    import nn_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int IDX_W  = NN_IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] class_score,
    output logic [IDX_W:0]    beat_count,
    output logic              overflow,
    output state_t            fsm_state
);

    // Counter saturates at 2^IDX_W, which needs one bit more than an index.
    localparam logic [IDX_W:0] CNT_FULL = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W:0] CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W:0]    cnt;
    logic [DATA_W-1:0] max_r;
    logic [IDX_W-1:0]  idx_r;
    logic              ovf_r;

    logic              accept;
    logic [DATA_W-1:0] cmp_max;
    logic [IDX_W-1:0]  cmp_idx;

    assign accept = in_valid && (state == ST_SCAN);

    argmax_cmp #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_cmp (
        .cand_val (in_data),
        .cand_idx (cnt[IDX_W-1:0]),
        .cur_max  (max_r),
        .cur_idx  (idx_r),
        .first    (cnt == '0),
        .next_max (cmp_max),
        .next_idx (cmp_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_SCAN: if (accept && in_last) state_nxt = ST_HOLD;
            ST_HOLD: if (out_ready)         state_nxt = ST_SCAN;
            default:                        state_nxt = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            max_r <= '0;
            idx_r <= '0;
            ovf_r <= 1'b0;
        end else if (state == ST_SCAN) begin
            if (accept) begin
                if (cnt == CNT_FULL) begin
                    // Beat beyond the layer capacity: flag it, keep the result.
                    ovf_r <= 1'b1;
                end else begin
                    max_r <= cmp_max;
                    idx_r <= cmp_idx;
                    cnt   <= cnt + CNT_ONE;
                end
            end
        end else if (out_ready) begin
            // max_r/idx_r are left alone; the first beat of the next layer
            // overwrites them because cnt is back at zero.
            cnt   <= '0;
            ovf_r <= 1'b0;
        end
    end

    assign in_ready    = (state == ST_SCAN);
    assign out_valid   = (state == ST_HOLD);
    assign class_idx   = idx_r;
    assign class_score = max_r;
    assign beat_count  = cnt;
    assign overflow    = ovf_r;
    assign fsm_state   = state;

endmodule
